// File: rtl/music_box_pkg.sv
// Shared types and defaults for the music box sequencer and its tempo helpers.
package music_box_pkg;

  typedef enum logic [1:0] {IDLE, REC, PLAY} state_e;

  localparam int unsigned NOTE_W_DEF = 5;
  localparam int unsigned REST_CODE  = 0;

endpackage

// File: rtl/music_box_sequencer_if.sv
// Keyboard/tempo inputs and tone-generator outputs of the music box sequencer.
interface music_box_sequencer_if #(
  parameter int unsigned NOTE_W = music_box_pkg::NOTE_W_DEF,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic              tempo_clk;
  logic              rec_en;
  logic              play_en;
  logic              key_valid;
  logic [NOTE_W-1:0] key_code;
  logic [NOTE_W-1:0] note_out;
  logic              note_valid;
  logic              recording;
  logic              playing;
  logic              full;
  logic [AW:0]       length;
  logic [AW-1:0]     step_idx;

  modport master (
    output tempo_clk, rec_en, play_en, key_valid, key_code,
    input  note_out, note_valid, recording, playing, full, length, step_idx
  );

  modport slave (
    input  tempo_clk, rec_en, play_en, key_valid, key_code,
    output note_out, note_valid, recording, playing, full, length, step_idx
  );

endinterface

// File: rtl/tempo_edge_detect.sv
// Registers a slow level and emits a one-cycle pulse on each rising edge.
module tempo_edge_detect (
  input  logic clkin,
  input  logic rst,
  input  logic level_in,
  output logic rise_pulse
);

  logic tempo_q;

  always_ff @(posedge clkin) begin
    if (rst) tempo_q <= 1'b0;
    else     tempo_q <= level_in;
  end

  assign rise_pulse = level_in & ~tempo_q;

endmodule

// File: rtl/music_box_sequencer.sv
// Records key codes into a small pattern memory and replays them, one note per tempo beat.
module music_box_sequencer
  import music_box_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NOTE_W = NOTE_W_DEF,
  parameter bit          LOOP   = 1'b1
) (
  input  logic                  clkin,
  input  logic                  rst,
  music_box_sequencer_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthL = DEPTH[AW:0];
  localparam logic [NOTE_W-1:0] Rest = NOTE_W'(REST_CODE);

  state_e            state_q, state_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              valid_q, valid_d;
  logic              full_q, full_d;
  logic [AW:0]       len_q, len_d;
  logic [AW-1:0]     step_q, step_d;
  logic [NOTE_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic              beat;
  logic [AW-1:0]     step_nxt;
  logic [AW:0]       last_idx;

  tempo_edge_detect u_beat (
    .clkin      (clkin),
    .rst        (rst),
    .level_in   (bus.tempo_clk),
    .rise_pulse (beat)
  );

  assign step_nxt = step_q + 1'b1;
  assign last_idx = len_q - 1'b1;

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    valid_d = valid_q;
    full_d  = full_q;
    len_d   = len_q;
    step_d  = step_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.rec_en) begin
          state_d = REC;
          len_d   = '0;
          full_d  = 1'b0;
        end else if (bus.play_en && (len_q != '0)) begin
          state_d = PLAY;
          step_d  = '0;
          note_d  = mem[0];
          valid_d = 1'b1;
        end
      end
      REC: begin
        // A key arriving with the falling rec_en is still captured.
        if (bus.key_valid && !full_q) begin
          wr_en  = 1'b1;
          len_d  = len_q + 1'b1;
          full_d = (len_q == DepthL - 1'b1);
        end
        if (!bus.rec_en) begin
          state_d = IDLE;
          note_d  = Rest;
          valid_d = 1'b0;
        end
      end
      PLAY: begin
        if (!bus.play_en || bus.rec_en) begin
          state_d = IDLE;
          note_d  = Rest;
          valid_d = 1'b0;
        end else if (beat) begin
          if ({1'b0, step_q} != last_idx) begin
            step_d = step_nxt;
            note_d = mem[step_nxt];
          end else if (LOOP) begin
            step_d = '0;
            note_d = mem[0];
          end else begin
            state_d = IDLE;
            note_d  = Rest;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q <= IDLE;
      note_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      len_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      valid_q <= valid_d;
      full_q  <= full_d;
      len_q   <= len_d;
      step_q  <= step_d;
    end
  end

  // Pattern memory is deliberately left out of reset.
  always_ff @(posedge clkin) begin
    if (wr_en) mem[len_q[AW-1:0]] <= bus.key_code;
  end

  assign bus.note_out   = note_q;
  assign bus.note_valid = valid_q;
  assign bus.recording  = (state_q == REC);
  assign bus.playing    = (state_q == PLAY);
  assign bus.full       = full_q;
  assign bus.length     = len_q;
  assign bus.step_idx   = step_q;

endmodule
